// File: rtl/bram_byte_write_adapter_if.sv
// Request, response and BRAM-port bundle for bram_byte_write_adapter.
// The adapter is the slave; the requester/BRAM side sees the master view.
interface bram_byte_write_adapter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [NUM_BYTES-1:0]  req_byte_en;
    logic [DATA_WIDTH-1:0] req_write_data;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  bram_readEnable;
    logic                  bram_writeEnable;
    logic [ADDR_WIDTH-1:0] bram_address;
    logic [DATA_WIDTH-1:0] bram_writeData;
    logic [DATA_WIDTH-1:0] bram_readData;

    logic                  rmw_busy;

    modport master (
        output req_valid, req_write, req_address, req_byte_en, req_write_data,
        input  req_ready,
        input  rsp_valid, rsp_data,
        input  bram_readEnable, bram_writeEnable, bram_address, bram_writeData,
        output bram_readData,
        input  rmw_busy
    );

    modport slave (
        input  req_valid, req_write, req_address, req_byte_en, req_write_data,
        output req_ready,
        output rsp_valid, rsp_data,
        output bram_readEnable, bram_writeEnable, bram_address, bram_writeData,
        input  bram_readData,
        output rmw_busy
    );
endinterface

// File: rtl/bram_byte_write_adapter.sv
// Byte-masked load/store front end for one port of dual_port_BRAM.
// Loads and full-word stores pass straight through; partial stores read the
// old word, then merge and write it back in a second (MERGE) cycle.
module bram_byte_write_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input logic                      clock,
    input logic                      reset,
    bram_byte_write_adapter_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_RESP,
        MERGE
    } state_t;

    state_t state;
    state_t next_state;

    logic                  ready;
    logic                  accept;
    logic                  is_full;
    logic                  is_empty;
    logic                  is_partial;
    logic                  rsp_fire;
    logic [ADDR_WIDTH-1:0] lat_address;
    logic [NUM_BYTES-1:0]  lat_mask;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [DATA_WIDTH-1:0] merged_data;
    logic [DATA_WIDTH-1:0] rsp_hold;

    // Ready depends only on state and reset, never on BRAM read data.
    assign ready      = reset && (state != MERGE);
    assign accept     = bus.req_valid && ready;
    assign is_full    = &bus.req_byte_en;
    assign is_empty   = ~|bus.req_byte_en;
    assign is_partial = bus.req_write && !is_full && !is_empty;
    assign rsp_fire   = reset && (state == RD_RESP);

    // State register; reset drops back to IDLE, aborting any pending merge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // RD_RESP behaves like IDLE for new requests; MERGE always finishes in one cycle.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, RD_RESP: begin
                if (accept) begin
                    if (!bus.req_write) begin
                        next_state = RD_RESP;
                    end else if (is_partial) begin
                        next_state = MERGE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the partial store so the merge can happen once the old word is back.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lat_address <= '0;
            lat_mask    <= '0;
            lat_data    <= '0;
        end else if (accept && is_partial) begin
            lat_address <= bus.req_address;
            lat_mask    <= bus.req_byte_en;
            lat_data    <= bus.req_write_data;
        end
    end

    // Hold the last returned word so rsp_data stays defined (0 after reset).
    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_hold <= '0;
        end else if (rsp_fire) begin
            rsp_hold <= bus.bram_readData;
        end
    end

    // Overlay the masked store bytes onto the word just read from the BRAM.
    always_comb begin
        merged_data = bus.bram_readData;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (lat_mask[i]) begin
                merged_data[8*i +: 8] = lat_data[8*i +: 8];
            end
        end
    end

    // Drive the BRAM port; read and write enables are mutually exclusive by construction.
    always_comb begin
        bus.req_ready        = ready;
        bus.rsp_valid        = rsp_fire;
        bus.rsp_data         = rsp_fire ? bus.bram_readData : rsp_hold;
        bus.rmw_busy         = 1'b0;
        bus.bram_readEnable  = 1'b0;
        bus.bram_writeEnable = 1'b0;
        bus.bram_address     = bus.req_address;
        bus.bram_writeData   = bus.req_write_data;
        if (state == MERGE) begin
            if (reset) begin
                bus.rmw_busy         = 1'b1;
                bus.bram_writeEnable = 1'b1;
                bus.bram_address     = lat_address;
                bus.bram_writeData   = merged_data;
            end
        end else if (accept) begin
            if (!bus.req_write || is_partial) begin
                bus.bram_readEnable = 1'b1;
            end else if (is_full) begin
                bus.bram_writeEnable = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bram_byte_write_adapter.sv
// Self-checking bench for bram_byte_write_adapter: a simple BRAM model plus a
// byte-addressed reference memory that predicts every cycle's outputs.
module tb_bram_byte_write_adapter;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    bram_byte_write_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_byte_write_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    logic [DW-1:0] bram_mem [0:DEPTH-1];

    // Single-port BRAM: synchronous write, registered read data one cycle later.
    always @(posedge clock) begin
        if (bus.bram_writeEnable) bram_mem[bus.bram_address] <= bus.bram_writeData;
        if (bus.bram_readEnable)  bus.bram_readData <= bram_mem[bus.bram_address];
    end

    // Reference model: memory as bytes, plus what is owed next cycle.
    logic [7:0]    ref_bytes [0:DEPTH*NB-1];
    logic          load_pending;
    logic [DW-1:0] load_data;
    logic          merge_pending;
    logic [AW-1:0] m_addr;
    logic [NB-1:0] m_mask;
    logic [DW-1:0] m_data;

    function automatic logic [DW-1:0] ref_word(input int a);
        logic [DW-1:0] w;
        for (int b = 0; b < NB; b++) w[8*b +: 8] = ref_bytes[a*NB + b];
        return w;
    endfunction

    task automatic ref_store(input int a, input logic [NB-1:0] mask, input logic [DW-1:0] data);
        for (int b = 0; b < NB; b++)
            if (mask[b]) ref_bytes[a*NB + b] = data[8*b +: 8];
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check all outputs against the model, advance the model.
    task automatic applyStimulus(input logic rst_level, input logic valid, input logic write,
                                 input logic [AW-1:0] addr, input logic [NB-1:0] mask,
                                 input logic [DW-1:0] data);
        logic          full, partial, exp_ready, acc, exp_re, exp_we, exp_rsp;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        @(negedge clock);
        reset              = rst_level;
        bus.req_valid      = valid;
        bus.req_write      = write;
        bus.req_address    = addr;
        bus.req_byte_en    = mask;
        bus.req_write_data = data;
        #1;
        full      = (mask == {NB{1'b1}});
        partial   = write && (mask != '0) && !full;
        exp_ready = rst_level && !merge_pending;
        acc       = valid && exp_ready;
        exp_re    = acc && (!write || partial);
        exp_we    = (merge_pending && rst_level) || (acc && write && full);
        exp_rsp   = load_pending && rst_level;
        if (merge_pending) begin
            exp_addr  = m_addr;
            exp_wdata = ref_word(int'(m_addr));
            for (int b = 0; b < NB; b++)
                if (m_mask[b]) exp_wdata[8*b +: 8] = m_data[8*b +: 8];
        end else begin
            exp_addr  = addr;
            exp_wdata = data;
        end
        checkOutput("req_ready", DW'(bus.req_ready), DW'(exp_ready));
        checkOutput("rsp_valid", DW'(bus.rsp_valid), DW'(exp_rsp));
        if (exp_rsp) checkOutput("rsp_data", bus.rsp_data, load_data);
        checkOutput("rmw_busy", DW'(bus.rmw_busy), DW'(merge_pending && rst_level));
        checkOutput("bram_readEnable", DW'(bus.bram_readEnable), DW'(exp_re));
        checkOutput("bram_writeEnable", DW'(bus.bram_writeEnable), DW'(exp_we));
        if (exp_re || exp_we) checkOutput("bram_address", DW'(bus.bram_address), DW'(exp_addr));
        if (exp_we) checkOutput("bram_writeData", bus.bram_writeData, exp_wdata);
        if (merge_pending && rst_level) ref_store(int'(m_addr), m_mask, m_data);
        if (acc && write && full) ref_store(int'(addr), mask, data);
        load_pending = acc && !write;
        if (acc && !write) load_data = ref_word(int'(addr));
        merge_pending = acc && partial;
        if (acc && partial) begin
            m_addr = addr;
            m_mask = mask;
            m_data = data;
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Directed test-plan scenarios, then a randomized regression, then a full memory sweep.
    initial begin
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_address    = '0;
        bus.req_byte_en    = '0;
        bus.req_write_data = '0;
        load_pending  = 1'b0;
        merge_pending = 1'b0;
        load_data     = '0;
        m_addr        = '0;
        m_mask        = '0;
        m_data        = '0;

        $display("[TB] reset, requests offered during reset must be ignored");
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 8'h10, '0, '0);
        idleCycle();
        checkOutput("rsp_data_after_reset", bus.rsp_data, 32'h0);

        $display("[TB] initialising memory with full-word stores");
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b1, 1'b1, AW'(a), 4'hF, $urandom);

        $display("[TB] single load");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 4'hF, 32'hA5A5_5A5A);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 4'h0, '0);
        idleCycle();
        checkOutput("load_0x10_valid", DW'(bus.rsp_valid), 32'd1);
        checkOutput("load_0x10_data", bus.rsp_data, 32'hA5A5_5A5A);

        $display("[TB] partial store");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 4'hF, 32'h1122_3344);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 4'b0101, 32'hAABB_CCDD);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, 4'h0, '0);
        checkOutput("partial_ready_low", DW'(bus.req_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, 4'h0, '0);
        idleCycle();
        checkOutput("partial_load", bus.rsp_data, 32'h11BB_33DD);
        checkOutput("partial_mem", bram_mem[8'h20], 32'h11BB_33DD);

        $display("[TB] full and empty masks");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h30, 4'hF, 32'hDEAD_BEEF);
        checkOutput("full_we", DW'(bus.bram_writeEnable), 32'd1);
        checkOutput("full_re", DW'(bus.bram_readEnable), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h31, 4'h0, 32'h1234_5678);
        checkOutput("empty_we", DW'(bus.bram_writeEnable), 32'd0);
        checkOutput("empty_re", DW'(bus.bram_readEnable), 32'd0);
        idleCycle();
        checkOutput("full_mem", bram_mem[8'h30], 32'hDEAD_BEEF);

        $display("[TB] back-to-back traffic");
        for (int a = 1; a <= 3; a++) applyStimulus(1'b1, 1'b1, 1'b0, AW'(a), 4'h0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h04, 4'hF, 32'h0000_00FF);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h04, 4'h0, '0);
        idleCycle();
        checkOutput("store_then_load", bus.rsp_data, 32'h0000_00FF);

        $display("[TB] reset during MERGE and during RD_RESP");
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h40, 4'hF, 32'h0102_0304);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h40, 4'b0011, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("rst_merge_we", DW'(bus.bram_writeEnable), 32'd0);
        checkOutput("rst_merge_ready", DW'(bus.req_ready), 32'd0);
        idleCycle();
        checkOutput("ready_after_reset", DW'(bus.req_ready), 32'd1);
        checkOutput("rst_merge_mem", bram_mem[8'h40], 32'h0102_0304);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h40, 4'h0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        checkOutput("rst_rdresp_valid", DW'(bus.rsp_valid), 32'd0);
        idleCycle();

        $display("[TB] random regression");
        for (int n = 0; n < 1000; n++) begin
            logic [NB-1:0] mask;
            int            pick;
            pick = int'($urandom_range(0, 5));
            if (pick == 0)      mask = '1;
            else if (pick == 1) mask = '0;
            else                mask = NB'($urandom);
            applyStimulus(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 9) != 0),
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), mask, $urandom);
        end
        idleCycle();
        idleCycle();

        for (int a = 0; a < DEPTH; a++) checkOutput("mem_final", bram_mem[a], ref_word(a));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
